wb2spram: RTL and testbench



---
 rtl/wb2spram_pkg.sv | 25 ++
 rtl/wb2spram.sv | 114 +++++++++++
 tb/tb_wb2spram.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb2spram_pkg.sv
// wb2spram shared types: FSM states, full-select constant, byte-lane merge.
// Used by the Wishbone-to-single-port-RAM bridge.
package wb2spram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  localparam logic [3:0] SEL_FULL = 4'hF;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb2spram.sv
// wb2spram: Wishbone B4 pipelined slave onto a 1-cycle synchronous single-port RAM.
// Partial writes use read-modify-write; WB2SPRAM_RANGE_CHECK_EN enables wb_err for wb_adr >= size.
module wb2spram
  import wb2spram_pkg::*;
#(
  parameter int size       = 65536,
  parameter int addr_width = $clog2(size) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [31:0]           wb_adr,
  input  logic [3:0]            wb_sel,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  wb_stall,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [31:0]           mem_d,
  input  logic [31:0]           mem_q
);

  state_t                state;
  logic [addr_width-1:0] held_addr;
  logic [3:0]            held_sel;
  logic [31:0]           held_dat;
  logic [31:0]           dat_hold;
  logic                  ack_r;
  logic                  err_r;
  logic                  rd_pend;
  logic                  is_merge;
  logic                  accept;
  logic                  oor;
  logic                  sel_full;
  logic                  sel_none;
  logic                  partial;
  logic                  unused;

  assign is_merge = (state == MERGE);
  assign wb_stall = is_merge;
  assign accept   = wb_cyc & wb_stb & ~is_merge;
  assign sel_full = (wb_sel == SEL_FULL);
  assign sel_none = (wb_sel == 4'h0);
  assign partial  = wb_we & ~sel_full & ~sel_none;

`ifdef WB2SPRAM_RANGE_CHECK_EN
  assign oor    = {1'b0, wb_adr} >= 33'(size);
  assign wb_err = err_r & wb_cyc;
  assign unused = ^{wb_adr[1:0]};
`else
  assign oor    = 1'b0;
  assign wb_err = 1'b0;
  assign unused = ^{wb_adr[31:addr_width+2], wb_adr[1:0], err_r};
`endif

  // Responses are registered but suppressed once the master drops cyc.
  assign wb_ack   = ack_r & wb_cyc;
  assign wb_dat_o = (rd_pend & wb_cyc) ? mem_q : dat_hold;

  // RAM port: straight from the bus in IDLE, merged write-back in MERGE.
  always_comb begin
    mem_addr = wb_adr[addr_width+1:2];
    mem_ce   = accept & ~oor & ~(wb_we & sel_none);
    mem_we   = accept & ~oor & wb_we & sel_full;
    mem_d    = wb_dat_i;
    if (is_merge) begin
      mem_addr = held_addr;
      mem_ce   = 1'b1;
      mem_we   = 1'b1;
      mem_d    = byte_merge(mem_q, held_dat, held_sel);
    end
    if (rst) begin
      mem_ce = 1'b0;
      mem_we = 1'b0;
    end
  end

  // FSM, response pulses and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      rd_pend   <= 1'b0;
      dat_hold  <= '0;
      held_addr <= '0;
      held_sel  <= '0;
      held_dat  <= '0;
    end else begin
      ack_r   <= is_merge | (accept & ~oor & ~partial);
      err_r   <= accept & oor;
      rd_pend <= accept & ~oor & ~wb_we;
      if (rd_pend & wb_cyc) dat_hold <= mem_q;
      case (state)
        IDLE: begin
          if (accept & ~oor & partial) begin
            state     <= MERGE;
            held_addr <= wb_adr[addr_width+1:2];
            held_sel  <= wb_sel;
            held_dat  <= wb_dat_i;
          end
        end
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb2spram.sv
// Bench for wb2spram: vector table, hand-written corner sequences, random traffic.
// Reference model is a byte-addressed memory plus an in-order response queue.
module tb_wb2spram;

  localparam int SIZE  = 65536;
  localparam int AW    = $clog2(SIZE) - 2;
  localparam int WORDS = SIZE / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic [31:0]   wb_adr = '0;
  logic [3:0]    wb_sel = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack;
  logic          wb_err;
  logic          wb_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_ce;
  logic          mem_we;
  logic [31:0]   mem_d;
  logic [31:0]   mem_q = '0;

  wb2spram #(.size(SIZE)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, read-before-write, registered output.
  logic [31:0] ram [0:WORDS-1];
  initial for (int i = 0; i < WORDS; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_d;
      mem_q <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        use_exp;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       exp_q[$];
  logic [7:0]  mdl [int unsigned];
  int          n_chk = 0;
  int          n_fail = 0;
  int          stall_due = -100;
  logic [AW-1:0] merge_a;
  logic [31:0] merge_w;
  logic [31:0] last_rd = '0;
  logic        pend_use = 1'b0;
  logic [31:0] pend_exp = '0;
  logic        last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & 32'(SIZE - 1) & ~32'd3;
  endfunction

  function automatic logic [31:0] word_rd(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    b = base_of(a);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (mdl.exists(b + 32'(i))) w[8*i +: 8] = mdl[b + 32'(i)];
    end
    return w;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
`ifdef WB2SPRAM_RANGE_CHECK_EN
    return a < 32'(SIZE);
`else
    return 1'b1;
`endif
  endfunction

  // Called at the negedge: checks this cycle's outputs and records any accept.
  task automatic observe();
    resp_t       e;
    logic        oor;
    logic        part;
    logic [31:0] a;
    logic [31:0] b;
    last_acc = 1'b0;
    chk("ack_err_excl", 32'(wb_ack & wb_err), 32'd0);
    chk("stall", 32'(wb_stall), 32'(stall_due == cyc));
    if (stall_due == cyc) begin
      chk("merge_ce_we", 32'({mem_ce, mem_we}), 32'd3);
      chk("merge_addr", 32'(mem_addr), 32'(merge_a));
      chk("merge_d", mem_d, merge_w);
    end
    if (wb_ack || wb_err) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_resp: got ack=%b err=%b expected none (cycle %0d)", wb_ack, wb_err, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", 32'(wb_err), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        if (e.rd) begin
          chk("rdata", wb_dat_o, e.data);
          last_rd = e.data;
        end
      end
    end else begin
      chk("dat_hold", wb_dat_o, last_rd);
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_resp: got none expected response due cycle %0d (cycle %0d)", exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
    end
    if (wb_cyc && wb_stb && !wb_stall) begin
      last_acc = 1'b1;
      a = wb_adr;
      b = base_of(a);
      oor = !in_range(a);
      part = wb_we && wb_sel != 4'hF && wb_sel != 4'h0;
      chk("mem_ce", 32'(mem_ce), 32'(!oor && !(wb_we && wb_sel == 4'h0)));
      chk("mem_we", 32'(mem_we), 32'(!oor && wb_we && wb_sel == 4'hF));
      if (!oor && mem_ce) chk("mem_addr", 32'(mem_addr), b >> 2);
      e.err  = oor;
      e.rd   = !oor && !wb_we;
      e.due  = cyc + ((part && !oor) ? 2 : 1);
      e.data = pend_use ? pend_exp : word_rd(a);
      if (!oor && wb_we) begin
        for (int i = 0; i < 4; i++) begin
          if (wb_sel[i]) mdl[b + 32'(i)] = wb_dat_i[8*i +: 8];
        end
      end
      if (part && !oor) begin
        stall_due = cyc + 1;
        merge_a   = AW'(b >> 2);
        merge_w   = word_rd(a);
      end
      exp_q.push_back(e);
    end
  endtask

  // Entered and left at posedge+1; holds the request until accepted.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic use_exp, input logic [31:0] exp);
    int n;
    n = 0;
    wb_stb = 1'b1;
    wb_we = we;
    wb_adr = adr;
    wb_sel = sel;
    wb_dat_i = dat;
    pend_use = use_exp;
    pend_exp = exp;
    do begin
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      n++;
    end while (!last_acc && n < 8);
    if (!last_acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got stall held expected accept (cycle %0d)", cyc);
    end
    wb_stb = 1'b0;
    pend_use = 1'b0;
  endtask

  task automatic idle(input int n);
    wb_stb = 1'b0;
    repeat (n) begin
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h20, 4'h2, 32'h0000AA00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 32'h1122AA44});
    tbl.push_back('{1'b1, 32'h30, 4'hF, 32'h5, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h30, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 32'h5});
    tbl.push_back('{1'b1, 32'h0, 4'hF, 32'h01010101, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h4, 4'hF, 32'h02020202, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h8, 4'hF, 32'h03030303, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'hC, 4'hF, 32'h04040404, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'h01010101});
    tbl.push_back('{1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'h02020202});
    tbl.push_back('{1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 32'h03030303});
    tbl.push_back('{1'b0, 32'hC, 4'hF, 32'h0, 1'b1, 32'h04040404});
    tbl.push_back('{1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'h02020202});
    tbl.push_back('{1'b1, 32'h8, 4'hC, 32'hAABB0000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 32'hAABB0303});
    tbl.push_back('{1'b0, 32'h00010000, 4'hF, 32'h0, 1'b1, 32'h01010101});
    tbl.push_back('{1'b1, 32'h00010014, 4'hF, 32'h77, 1'b0, 32'h0});
`ifdef WB2SPRAM_RANGE_CHECK_EN
    tbl.push_back('{1'b0, 32'h14, 4'hF, 32'h0, 1'b1, 32'h0});
`else
    tbl.push_back('{1'b0, 32'h14, 4'hF, 32'h0, 1'b1, 32'h77});
`endif

    // Reset state, with a stray strobe outside a bus cycle.
    wb_cyc = 1'b0;
    wb_stb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_stall", 32'(wb_stall), 32'd0);
    chk("rst_ce_we", 32'({mem_ce, mem_we}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb_stb = 1'b0;
    wb_cyc = 1'b1;

    foreach (tbl[k]) begin
      issue(tbl[k].we, tbl[k].adr, tbl[k].sel, tbl[k].dat, tbl[k].use_exp, tbl[k].exp);
    end
    idle(4);

    // Response cycle with cyc low: pulse suppressed, no late ack, data held.
    wb_we = 1'b0;
    wb_adr = 32'h10;
    wb_sel = 4'hF;
    wb_stb = 1'b1;
    @(negedge clk);
    chk("cl_accept", 32'(wb_stall), 32'd0);
    @(posedge clk);
    #1;
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    @(negedge clk);
    chk("cl_ack_forced", 32'(wb_ack), 32'd0);
    chk("cl_dat_hold", wb_dat_o, last_rd);
    @(posedge clk);
    #1;
    wb_cyc = 1'b1;
    @(negedge clk);
    chk("cl_no_late_ack", 32'(wb_ack), 32'd0);
    @(posedge clk);
    #1;

    // Reset during MERGE: write abandoned, word unchanged.
    issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    idle(3);
    wb_we = 1'b1;
    wb_adr = 32'h40;
    wb_sel = 4'b0001;
    wb_dat_i = 32'h00000011;
    wb_stb = 1'b1;
    @(negedge clk);
    chk("rm_accept", 32'(wb_stall), 32'd0);
    chk("rm_read_ce_we", 32'({mem_ce, mem_we}), 32'd2);
    @(posedge clk);
    #1;
    wb_stb = 1'b0;
    chk("rm_merge_stall", 32'(wb_stall), 32'd1);
    chk("rm_merge_d", mem_d, 32'hCAFEF011);
    rst = 1'b1;
    #1;
    chk("rm_ce_drop", 32'(mem_ce), 32'd0);
    chk("rm_stall_drop", 32'(wb_stall), 32'd0);
    @(negedge clk);
    chk("rm_no_ack", 32'(wb_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = '0;
    stall_due = -100;
    @(negedge clk);
    chk("rm_no_ack2", 32'(wb_ack), 32'd0);
    chk("rm_dat_reset", wb_dat_o, 32'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'hCAFEF00D);
    idle(3);

    // Random pipelined traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = {24'h0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 9) == 0) a = a + 32'h10000 * 32'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = 4'($urandom_range(1, 14));
      endcase
      issue(1'($urandom_range(0, 1)), a, s, $urandom, 1'b0, 32'h0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
